// File: rtl/cnn_pkg.sv
// Shared CNN top-level definitions.
// Holds the image/window geometry used by the read sequencer and the result
// packer, the default number of results per frame, and the TX FSM state type.
package cnn_pkg;

    localparam int unsigned IMG_W = 28;
    // A 3x3 window slides over the image without padding.
    localparam int unsigned WIN_W = IMG_W - 2;
    // One classification result per window position.
    localparam int unsigned NUM_BITS_DEFAULT = WIN_W * WIN_W;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } tx_state_t;

endpackage

// File: rtl/cnn_byte_fifo.sv
// Byte buffer between the result packer and the UART transmitter.
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   push, din     write request and 9-bit entry {last, byte}
//   pop, dout     read request and head entry (valid while !empty)
//   full, empty   occupancy flags
//   drop          pulse: a push was discarded because the buffer was full
// A push into a full buffer is honoured only when a pop happens on the same
// edge; the slot being vacated is the one being written.
module cnn_byte_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [8:0] din,
    output logic [8:0] dout,
    output logic       full,
    output logic       empty,
    output logic       drop
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [8:0]  mem [DEPTH];
    logic [AW:0] wr_ptr_q;
    logic [AW:0] rd_ptr_q;
    logic        do_push;
    logic        do_pop;

    // Extra pointer MSB distinguishes full from empty when lower bits match.
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign drop    = push && full && !do_pop;
    assign dout    = mem[rd_ptr_q[AW-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    // Storage needs no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!rst && do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/cnn_tx_packer.sv
// Packs per-window 1-bit results from cnn_core LSB-first into bytes, buffers
// them and feeds the UART transmitter through a trmt/tx_done handshake.
// A frame is NUM_BITS results; its trailing partial byte is zero-padded.
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   bit_vld, bit_in    result strobe and result bit
//   tx_done            UART finished the current byte
//   trmt, tx_data      start pulse and byte to send (held until tx_done)
//   bsy                something is pending in the packer, buffer or UART
//   frame_done         pulse after the last byte of a frame has been sent
//   ovf                sticky: a byte was lost to a full buffer
module cnn_tx_packer
    import cnn_pkg::*;
#(
    parameter int unsigned NUM_BITS   = NUM_BITS_DEFAULT,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_vld,
    input  logic       bit_in,
    input  logic       tx_done,
    output logic       trmt,
    output logic [7:0] tx_data,
    output logic       bsy,
    output logic       frame_done,
    output logic       ovf
);

    localparam int unsigned    FCW       = $clog2(NUM_BITS);
    localparam logic [FCW-1:0] FCNT_LAST = FCW'(NUM_BITS - 1);
    localparam logic [FCW-1:0] FCNT_ONE  = FCW'(1);

    logic [7:0]     sr_q;
    logic [2:0]     idx_q;
    logic [FCW-1:0] fcnt_q;
    logic [7:0]     byte_merged;
    logic           last_bit;
    logic           push;
    logic           pop;
    logic [8:0]     fifo_dout;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_drop;
    tx_state_t      state_q;
    logic           last_q;

    // Bits above idx are still zero from the previous clear, which gives the
    // padding of the frame's final partial byte for free.
    always_comb begin
        byte_merged        = sr_q;
        byte_merged[idx_q] = bit_in;
    end

    assign last_bit = (fcnt_q == FCNT_LAST);
    assign push     = bit_vld && ((idx_q == 3'd7) || last_bit);
    assign pop      = (state_q == IDLE) && !fifo_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            sr_q   <= '0;
            idx_q  <= '0;
            fcnt_q <= '0;
        end else if (bit_vld) begin
            if (push) begin
                sr_q  <= '0;
                idx_q <= '0;
            end else begin
                sr_q  <= byte_merged;
                idx_q <= idx_q + 3'd1;
            end
            fcnt_q <= last_bit ? '0 : fcnt_q + FCNT_ONE;
        end
    end

    cnn_byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   ({last_bit, byte_merged}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .drop  (fifo_drop)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (fifo_drop) begin
            ovf <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            trmt       <= 1'b0;
            tx_data    <= 8'h00;
            last_q     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            trmt       <= 1'b0;
            frame_done <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (!fifo_empty) begin
                        state_q <= SEND;
                        trmt    <= 1'b1;
                        tx_data <= fifo_dout[7:0];
                        last_q  <= fifo_dout[8];
                    end
                end
                SEND: begin
                    if (tx_done) begin
                        state_q    <= IDLE;
                        frame_done <= last_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bsy = (idx_q != 3'd0) || !fifo_empty || fifo_full || (state_q != IDLE);

endmodule

// File: tb/tb_cnn_tx_packer.sv
module tb_cnn_tx_packer;
    import cnn_pkg::*;

    localparam int NB    = 676;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_vld;
    logic       bit_in;
    logic       tx_done;
    logic       trmt;
    logic [7:0] tx_data;
    logic       bsy;
    logic       frame_done;
    logic       ovf;

    cnn_tx_packer #(
        .NUM_BITS   (NB),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_vld    (bit_vld),
        .bit_in     (bit_in),
        .tx_done    (tx_done),
        .trmt       (trmt),
        .tx_data    (tx_data),
        .bsy        (bsy),
        .frame_done (frame_done),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model: bytes the UART should see, built from the bit stream.
    logic [7:0] exp_q[$];
    logic [7:0] m_acc;
    int         m_nbits;
    int         m_fbits;

    function automatic void model_reset();
        exp_q.delete();
        m_acc   = 8'h00;
        m_nbits = 0;
        m_fbits = 0;
    endfunction

    function automatic void model_bit(input logic b);
        m_acc = m_acc | (8'(b) << m_nbits);
        m_nbits++;
        m_fbits++;
        if (m_nbits == 8 || m_fbits == NB) begin
            exp_q.push_back(m_acc);
            m_acc   = 8'h00;
            m_nbits = 0;
        end
        if (m_fbits == NB) m_fbits = 0;
    endfunction

    // UART responder: captures each trmt byte, answers tx_done after resp_delay
    // cycles unless held, and records frame_done timing.
    int         resp_delay;
    bit         resp_hold;
    int         done_req;
    int         clear_req;
    logic [7:0] got_q[$];
    int         cyc;
    int         cnt;
    int         done_cnt;
    int         fd_cnt;
    int         fd_idx;
    int         fd_gap;
    int         last_done_cyc;
    int         trmt_wide;
    int         unstable;
    logic [7:0] cur;
    logic       prev_trmt;

    initial begin
        int done_seen;
        int clear_seen;
        done_seen = 0; clear_seen = 0;
        tx_done = 1'b0; cyc = 0; cnt = 0; done_cnt = 0; fd_cnt = 0; fd_idx = -1;
        fd_gap = -1; last_done_cyc = 0; trmt_wide = 0; unstable = 0; cur = 8'h00;
        prev_trmt = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            tx_done = 1'b0;
            if (clear_req != clear_seen) begin
                clear_seen = clear_req;
                got_q.delete();
                cnt = 0; done_cnt = 0; fd_cnt = 0; fd_idx = -1; fd_gap = -1;
                trmt_wide = 0; unstable = 0; prev_trmt = 1'b0;
            end
            if (frame_done) begin
                fd_cnt++;
                fd_idx = done_cnt;
                fd_gap = cyc - last_done_cyc;
            end
            if (cnt > 0 && !resp_hold) begin
                cnt--;
                if (cnt == 0) begin
                    tx_done = 1'b1;
                    done_cnt++;
                    last_done_cyc = cyc;
                end
            end
            if (cnt > 0 && tx_data !== cur) unstable++;
            if (done_req != done_seen) begin
                done_seen = done_req;
                tx_done = 1'b1;
                cnt = 0;
                done_cnt++;
                last_done_cyc = cyc;
            end
            if (trmt) begin
                if (prev_trmt) trmt_wide++;
                got_q.push_back(tx_data);
                cur = tx_data;
                cnt = resp_delay;
            end
            prev_trmt = trmt;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bit_vld = 1'b0;
        tick();
        clear_req++;
        model_reset();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_bit(input logic b, input int gap);
        bit_vld = 1'b1;
        bit_in  = b;
        model_bit(b);
        tick();
        bit_vld = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic send_rand(input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            logic b;
            b = 1'($urandom_range(0, 1));
            send_bit(b, $urandom_range(gap_max > 0 ? 1 : 0, gap_max));
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int k;
        k = 0;
        while ((got_q.size() < exp_q.size() || bsy || cnt != 0) && k < budget) begin
            tick();
            k++;
        end
        check_eq(tag, 32'(k >= budget), 32'd0);
        repeat (3) tick();
    endtask

    task automatic compare_bytes(input string tag);
        int n;
        check_eq({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) check_eq($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] pat;
        int         bsy_low;
        int         fd_seen;
        rst = 1'b1; bit_vld = 1'b0; bit_in = 1'b0;
        resp_delay = 10; resp_hold = 1'b0; done_req = 0; clear_req = 0;
        model_reset();
        do_reset();

        // Reset state
        check_eq("rst_trmt", trmt, 1'b0);
        check_eq("rst_bsy", bsy, 1'b0);
        check_eq("rst_tx_data", tx_data, 8'h00);
        check_eq("rst_ovf", ovf, 1'b0);
        check_eq("rst_frame_done", frame_done, 1'b0);

        // Single byte 1,0,1,1,0,0,0,1 -> 8'h8D
        pat = 8'b1000_1101;
        for (int i = 0; i < 8; i++) send_bit(pat[i], 0);
        check_eq("single_trmt_n1", trmt, 1'b0);
        check_eq("single_bsy_n1", bsy, 1'b1);
        tick();
        check_eq("single_trmt_n2", trmt, 1'b1);
        check_eq("single_data", tx_data, 8'h8D);
        bsy_low = 0;
        for (int k = 3; k <= 12; k++) begin
            tick();
            if (k == 3) check_eq("single_trmt_n3", trmt, 1'b0);
            if (!bsy) bsy_low++;
        end
        check_eq("single_bsy_until_done", bsy_low, 0);
        tick();
        check_eq("single_bsy_after_done", bsy, 1'b0);
        compare_bytes("single");

        // Full frame of ones. A bit every other cycle: the UART drains one byte
        // per 12 cycles with a 10-cycle tx_done, slower than one bit per cycle.
        do_reset();
        resp_delay = 10;
        for (int i = 0; i < NB; i++) send_bit(1'b1, 1);
        drain("frame_drain", 3000);
        compare_bytes("frame");
        if (got_q.size() == 85) check_eq("frame_tail", got_q[84], 8'h0F);
        check_eq("frame_fd_cnt", fd_cnt, 1);
        check_eq("frame_fd_idx", fd_idx, 85);
        check_eq("frame_fd_gap", fd_gap, 1);
        check_eq("frame_ovf", ovf, 1'b0);
        check_eq("frame_trmt_wide", trmt_wide, 0);
        check_eq("frame_data_stable", unstable, 0);

        // Spurious tx_done in IDLE, right after a frame ended
        done_req++;
        fd_seen = 0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (frame_done || trmt || bsy) fd_seen++;
        end
        check_eq("spurious_no_effect", fd_seen, 0);
        check_eq("spurious_fd_cnt", fd_cnt, 1);

        // Backpressure: 1 in flight + 4 queued, then the 6th byte is lost
        do_reset();
        resp_hold = 1'b1;
        send_rand(40, 0);
        repeat (3) tick();
        check_eq("bp_in_flight", got_q.size(), 1);
        check_eq("bp_bsy", bsy, 1'b1);
        check_eq("bp_ovf_before", ovf, 1'b0);
        send_rand(8, 0);
        check_eq("bp_ovf_set", ovf, 1'b1);
        exp_q.delete(5);
        resp_hold = 1'b0;
        drain("bp_drain", 1000);
        compare_bytes("bp");
        check_eq("bp_ovf_sticky", ovf, 1'b1);

        // Full buffer, byte completes on the same edge as a pop
        do_reset();
        resp_hold = 1'b1;
        send_rand(47, 0);
        done_req++;
        tick();
        send_bit(1'($urandom_range(0, 1)), 0);
        tick();
        check_eq("simul_no_drop", ovf, 1'b0);
        send_rand(8, 0);
        check_eq("simul_still_full", ovf, 1'b1);
        exp_q.delete(6);
        resp_hold = 1'b0;
        drain("simul_drain", 1000);
        compare_bytes("simul");

        // Reset in mid-operation, with a strobe on the reset cycle
        do_reset();
        resp_delay = 10;
        send_rand(8, 0);
        send_rand(3, 0);
        rst = 1'b1;
        bit_vld = 1'b1;
        bit_in = 1'b1;
        clear_req++;
        model_reset();
        tick();
        rst = 1'b0;
        bit_vld = 1'b0;
        check_eq("midrst_trmt", trmt, 1'b0);
        check_eq("midrst_bsy", bsy, 1'b0);
        check_eq("midrst_tx_data", tx_data, 8'h00);
        resp_delay = $urandom_range(1, 10);
        send_rand(NB, 2);
        drain("midrst_drain", 4000);
        compare_bytes("midrst");
        check_eq("midrst_fd_cnt", fd_cnt, 1);
        check_eq("midrst_fd_idx", fd_idx, 85);
        check_eq("midrst_fd_gap", fd_gap, 1);
        check_eq("midrst_ovf", ovf, 1'b0);
        check_eq("midrst_data_stable", unstable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
